// File: rtl/systolic_array_param.sv
// Weight-stationary systolic array of signed fixed-point MAC PEs with double-buffered
// weights, diagonal weight-swap propagation and a runtime limit on enabled columns.
module systolic_array_param #(
  parameter int ROWS     = 2,
  parameter int COLS     = 2,
  parameter int DATA_W   = 16,
  parameter int FRAC     = 8,
  parameter int SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ROWS*DATA_W-1:0]   sys_data_in,
  input  logic [ROWS-1:0]          sys_valid_in,
  input  logic [COLS*DATA_W-1:0]   sys_weight_in,
  input  logic [COLS-1:0]          sys_accept_w,
  input  logic                     sys_switch_in,
  input  logic [15:0]              ub_rd_col_size_in,
  input  logic                     ub_rd_col_size_valid_in,
  output logic [COLS*DATA_W-1:0]   sys_data_out,
  output logic [COLS-1:0]          sys_valid_out
);

  typedef logic signed [DATA_W-1:0] word_t;

  localparam int    PROD_W   = 2 * DATA_W;
  localparam int    SUM_W    = 2 * DATA_W + 1;
  localparam word_t WORD_MAX = word_t'({1'b0, {(DATA_W-1){1'b1}}});
  localparam word_t WORD_MIN = word_t'({1'b1, {(DATA_W-1){1'b0}}});

  function automatic word_t mac(input word_t a, input word_t w, input word_t p);
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  sum;
    prod = PROD_W'(a) * PROD_W'(w);
    // Keep the whole shifted product so an oversized result clamps rather than aliasing.
    sum  = SUM_W'(prod >>> FRAC) + SUM_W'(p);
    if (SATURATE != 0) begin
      if (sum > SUM_W'(WORD_MAX)) return WORD_MAX;
      if (sum < SUM_W'(WORD_MIN)) return WORD_MIN;
    end
    return word_t'(sum[DATA_W-1:0]);
  endfunction

  // Per-PE state
  word_t w_inact  [ROWS][COLS];
  word_t w_act    [ROWS][COLS];
  word_t act_q    [ROWS][COLS];
  word_t psum_q   [ROWS][COLS];
  logic  valid_q  [ROWS][COLS];
  logic  switch_q [ROWS][COLS];
  logic [15:0] col_size;

  // Per-PE inputs, gathered from neighbours or from the array edge
  word_t act_w    [ROWS][COLS];
  logic  valid_w  [ROWS][COLS];
  logic  sw_w     [ROWS][COLS];
  word_t w_n      [ROWS][COLS];
  word_t psum_n   [ROWS][COLS];
  logic [15:0]     col_size_nxt;
  logic [COLS-1:0] col_en;

  // NOTE: every element of every array below is written on each pass, so no latch can form.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      act_w[r][0]   = word_t'(sys_data_in[r*DATA_W +: DATA_W]);
      valid_w[r][0] = sys_valid_in[r];
      for (int c = 1; c < COLS; c++) begin
        act_w[r][c]   = act_q[r][c-1];
        valid_w[r][c] = valid_q[r][c-1];
        sw_w[r][c]    = switch_q[r][c-1];
      end
    end
    sw_w[0][0] = sys_switch_in;
    for (int r = 1; r < ROWS; r++) begin
      sw_w[r][0] = switch_q[r-1][0];
    end
    for (int c = 0; c < COLS; c++) begin
      w_n[0][c]    = word_t'(sys_weight_in[c*DATA_W +: DATA_W]);
      psum_n[0][c] = '0;
      for (int r = 1; r < ROWS; r++) begin
        w_n[r][c]    = w_inact[r-1][c];
        psum_n[r][c] = psum_q[r-1][c];
      end
    end
  end

  // A freshly latched column count already gates the PEs on the edge that latches it.
  always_comb begin
    col_size_nxt = col_size;
    if (ub_rd_col_size_valid_in) begin
      col_size_nxt = (ub_rd_col_size_in > 16'(COLS)) ? 16'(COLS) : ub_rd_col_size_in;
    end
    col_en = '0;
    for (int c = 0; c < COLS; c++) begin
      col_en[c] = (16'(c) < col_size_nxt);
    end
  end

  // NOTE: the PE registers are reset too, because a reset must discard loaded weights and sums.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_size <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          w_inact[r][c]  <= '0;
          w_act[r][c]    <= '0;
          act_q[r][c]    <= '0;
          psum_q[r][c]   <= '0;
          valid_q[r][c]  <= 1'b0;
          switch_q[r][c] <= 1'b0;
        end
      end
    end else begin
      col_size <= col_size_nxt;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (sys_accept_w[c]) w_inact[r][c] <= w_n[r][c];
          // NOTE: non-blocking, so a swap coinciding with a shift captures the pre-shift weight.
          if (sw_w[r][c]) w_act[r][c] <= w_inact[r][c];
          switch_q[r][c] <= sw_w[r][c];
          act_q[r][c]    <= act_w[r][c];
          if (col_en[c]) begin
            valid_q[r][c] <= valid_w[r][c];
            psum_q[r][c]  <= valid_w[r][c] ? mac(act_w[r][c], w_act[r][c], psum_n[r][c]) : '0;
          end else begin
            valid_q[r][c] <= 1'b0;
            psum_q[r][c]  <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    sys_data_out  = '0;
    sys_valid_out = '0;
    for (int c = 0; c < COLS; c++) begin
      sys_data_out[c*DATA_W +: DATA_W] = psum_q[ROWS-1][c];
      sys_valid_out[c]                 = valid_q[ROWS-1][c];
    end
  end

endmodule

// File: tb/tb_systolic_array_param.sv
// Directed bench for systolic_array_param: a saturating and a wrapping instance share
// the same stimulus and are compared against hand-computed Q8.8 results.
module tb_systolic_array_param;

  localparam int ROWS   = 2;
  localparam int COLS   = 2;
  localparam int DATA_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [ROWS*DATA_W-1:0] sys_data_in;
  logic [ROWS-1:0]        sys_valid_in;
  logic [COLS*DATA_W-1:0] sys_weight_in;
  logic [COLS-1:0]        sys_accept_w;
  logic                   sys_switch_in;
  logic [15:0]            ub_rd_col_size_in;
  logic                   ub_rd_col_size_valid_in;
  logic [COLS*DATA_W-1:0] data_sat, data_wrap;
  logic [COLS-1:0]        valid_sat, valid_wrap;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  systolic_array_param #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .FRAC(8), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst),
    .sys_data_in(sys_data_in), .sys_valid_in(sys_valid_in),
    .sys_weight_in(sys_weight_in), .sys_accept_w(sys_accept_w),
    .sys_switch_in(sys_switch_in),
    .ub_rd_col_size_in(ub_rd_col_size_in), .ub_rd_col_size_valid_in(ub_rd_col_size_valid_in),
    .sys_data_out(data_sat), .sys_valid_out(valid_sat)
  );

  systolic_array_param #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .FRAC(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst),
    .sys_data_in(sys_data_in), .sys_valid_in(sys_valid_in),
    .sys_weight_in(sys_weight_in), .sys_accept_w(sys_accept_w),
    .sys_switch_in(sys_switch_in),
    .ub_rd_col_size_in(ub_rd_col_size_in), .ub_rd_col_size_valid_in(ub_rd_col_size_valid_in),
    .sys_data_out(data_wrap), .sys_valid_out(valid_wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] exp_d, input logic [1:0] exp_v);
    check({tag, "_sat_data"},   data_sat,             exp_d);
    check({tag, "_sat_valid"},  {30'b0, valid_sat},   {30'b0, exp_v});
    check({tag, "_wrap_data"},  data_wrap,            exp_d);
    check({tag, "_wrap_valid"}, {30'b0, valid_wrap},  {30'b0, exp_v});
  endtask

  // Inputs change at the falling edge; outputs are sampled there as well.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    sys_data_in             = '0;
    sys_valid_in            = '0;
    sys_weight_in           = '0;
    sys_accept_w            = '0;
    sys_switch_in           = 1'b0;
    ub_rd_col_size_in       = '0;
    ub_rd_col_size_valid_in = 1'b0;
  endtask

  task automatic set_col_size(input logic [15:0] n);
    ub_rd_col_size_in       = n;
    ub_rd_col_size_valid_in = 1'b1;
    tick();
    ub_rd_col_size_valid_in = 1'b0;
  endtask

  // Bottom-row weights are fed first, then top-row weights.
  task automatic load_w(input logic [31:0] bottom, input logic [31:0] top, input logic [1:0] acc);
    sys_accept_w  = acc;
    sys_weight_in = bottom;
    tick();
    sys_weight_in = top;
    tick();
    sys_accept_w  = '0;
    sys_weight_in = '0;
  endtask

  task automatic do_switch();
    sys_switch_in = 1'b1;
    tick();
    sys_switch_in = 1'b0;
  endtask

  // W = [[1.0, 4.34765625], [5.75, 1.0]]
  task automatic load_main_weights();
    load_w({16'h0100, 16'h05C0}, {16'h0459, 16'h0100}, 2'b11);
    do_switch();
  endtask

  // A = [[1,2],[5,6]] streamed with row 1 skewed by one cycle.
  task automatic stream(input string tag, input bit col1_on);
    logic [31:0] dd [4] = '{32'h0000_0100, 32'h0200_0500, 32'h0600_0000, 32'h0000_0000};
    logic [1:0]  dv [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [31:0] ed [5] = '{32'h0000_0000, 32'h0000_0C80, 32'h0659_2780, 32'h1BBD_0000, 32'h0000_0000};
    logic [1:0]  ev [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [31:0] exp_d;
    logic [1:0]  exp_v;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        sys_data_in  = dd[i];
        sys_valid_in = dv[i];
      end else begin
        sys_data_in  = '0;
        sys_valid_in = '0;
      end
      tick();
      exp_d = col1_on ? ed[i] : {16'h0000, ed[i][15:0]};
      exp_v = col1_on ? ev[i] : {1'b0, ev[i][0]};
      check_outs($sformatf("%s_e%0d", tag, i + 1), exp_d, exp_v);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("reset", 32'h0, 2'b00);
    rst = 1'b1;
    tick();

    // Column 0 weight shift without a swap
    load_w({16'h0000, 16'h05C0}, {16'h0000, 16'h0100}, 2'b01);
    check("wload_inact00", {16'h0, dut_sat.w_inact[0][0]}, 32'h0000_0100);
    check("wload_inact10", {16'h0, dut_sat.w_inact[1][0]}, 32'h0000_05C0);
    check("wload_act00",   {16'h0, dut_sat.w_act[0][0]},   32'h0000_0000);
    check("wload_act10",   {16'h0, dut_sat.w_act[1][0]},   32'h0000_0000);

    set_col_size(16'd2);
    load_main_weights();
    stream("mm", 1'b1);

    // Clamp versus wrap: W(0,0)=100.0, W(1,0)=0, activation 100.0
    load_w({16'h0000, 16'h0000}, {16'h0000, 16'h6400}, 2'b01);
    do_switch();
    sys_data_in  = {16'h0000, 16'h6400};
    sys_valid_in = 2'b01;
    tick();
    sys_data_in  = '0;
    sys_valid_in = 2'b10;
    tick();
    check("sat_data",   {16'h0, data_sat[15:0]},  32'h0000_7FFF);
    check("wrap_data",  {16'h0, data_wrap[15:0]}, 32'h0000_1000);
    check("sat_valid",  {31'b0, valid_sat[0]},    32'h1);
    check("wrap_valid", {31'b0, valid_wrap[0]},   32'h1);
    sys_valid_in = '0;
    tick();

    // Column 1 disabled, then an oversized count that must clamp
    set_col_size(16'd1);
    load_main_weights();
    stream("cs1", 1'b0);
    set_col_size(16'd40);
    check("cs40_clamp", {16'h0, dut_sat.col_size}, 32'h0000_0002);
    stream("cs40", 1'b1);

    // Asynchronous reset between edges in the middle of a stream
    set_col_size(16'd2);
    load_main_weights();
    sys_data_in  = 32'h0000_0100;
    sys_valid_in = 2'b01;
    tick();
    sys_data_in  = 32'h0200_0500;
    sys_valid_in = 2'b11;
    tick();
    check("pre_rst_col0", {16'h0, data_sat[15:0]}, 32'h0000_0C80);
    #2 rst = 1'b0;
    #1;
    check_outs("async_rst", 32'h0, 2'b00);
    check("rst_col_size", {16'h0, dut_sat.col_size},     32'h0);
    check("rst_act00",    {16'h0, dut_sat.w_act[0][0]},  32'h0);
    check("rst_inact10",  {16'h0, dut_sat.w_inact[1][0]}, 32'h0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_outs("post_rst", 32'h0, 2'b00);
    set_col_size(16'd2);
    load_main_weights();
    stream("rerun", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
